stoch_add_seq: RTL

Sequencer for a stochastic adder datapath. It accepts two unipolar fixed-point operands over a valid/ready handshake and converts each into a deterministic bitstream with an LFSR-based stream generator. It drives the streams into an external counter-based stochastic adder for one full LFSR period, counts the adder's output ones, and returns the count as a fixed-point result. It sits between a fixed-point host (controller or bus shim) and the stochastic add datapath, and owns the adder's reset.

---
 rtl/stoch_pkg.sv | 49 ++++
 rtl/stoch_sng.sv | 47 ++++
 rtl/stoch_add_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/stoch_pkg.sv
// -----------------------------------------------------------------------------
// stoch_pkg
// Shared definitions for the stochastic adder sequencer.
//   state_t    : sequencer FSM states (IDLE, RUN, DONE)
//   lfsr_taps  : maximal-length Fibonacci tap mask for a given LFSR width.
//                Bit k-1 of the mask is set when stage k feeds the XOR.
//   width_ok   : legal operand/result width range check
// -----------------------------------------------------------------------------
package stoch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 16;

  // Tap sets are primitive polynomials, e.g. WIDTH 8 -> x^8+x^6+x^5+x^4+1.
  // Any width outside the table returns 0, which the top rejects at
  // elaboration before it can ever be used.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] mask;
    mask = 16'h0000;
    case (width)
      4:       mask = 16'h000C; // 4,3
      5:       mask = 16'h0014; // 5,3
      6:       mask = 16'h0030; // 6,5
      7:       mask = 16'h0060; // 7,6
      8:       mask = 16'h00B8; // 8,6,5,4
      9:       mask = 16'h0110; // 9,5
      10:      mask = 16'h0240; // 10,7
      11:      mask = 16'h0500; // 11,9
      12:      mask = 16'h0829; // 12,6,4,1
      13:      mask = 16'h100D; // 13,4,3,1
      14:      mask = 16'h2015; // 14,5,3,1
      15:      mask = 16'h6000; // 15,14
      16:      mask = 16'hD008; // 16,15,13,4
      default: mask = 16'h0000;
    endcase
    return mask;
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/stoch_sng.sv
// -----------------------------------------------------------------------------
// stoch_sng
// Stochastic number generator: a maximal-length Fibonacci LFSR compared
// against an operand. Over one full LFSR period (2^WIDTH-1 steps) the LFSR
// visits every value 1..2^WIDTH-1 exactly once, so with a <= comparison the
// stream carries exactly `value` ones.
//   CLK      in   clock, posedge
//   load     in   load LFSR with seed (takes priority over en)
//   en       in   advance the LFSR one step
//   seed     in   LFSR load value, must be nonzero
//   value    in   operand the LFSR is compared against
//   bit_out  out  (lfsr <= value), combinational from the LFSR register
// The LFSR has no reset of its own: it is always loaded before it is used,
// and the owner gates bit_out whenever the stream is not live.
// -----------------------------------------------------------------------------
module stoch_sng
  import stoch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] value,
  output logic             bit_out
);

  localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] lfsr_reg;
  logic             feedback;

  assign feedback = ^(lfsr_reg & TAPS);

  always_ff @(posedge CLK) begin
    if (load) begin
      lfsr_reg <= seed;
    end else if (en) begin
      lfsr_reg <= {lfsr_reg[WIDTH-2:0], feedback};
    end
  end

  assign bit_out = (lfsr_reg <= value);

endmodule

// File: rtl/stoch_add_seq.sv
// -----------------------------------------------------------------------------
// stoch_add_seq
// Sequencer for an external counter-based stochastic adder. Accepts an
// operand pair, streams both operands as deterministic bitstreams into the
// adder for one full LFSR period (N = 2^WIDTH-1 cycles), counts the adder's
// output ones and returns the count.
//   CLK        in   clock, posedge
//   nRST       in   synchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  ready for operands (IDLE only)
//   op_a/op_b  in   operands, value op/N
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts the result
//   result     out  ones counted over the run
//   busy       out  high whenever not IDLE
//   dp_nrst    out  adder reset, released only while streaming
//   dp_a/dp_b  out  stream bits to the adder
//   dp_y       in   adder output bit
// Timing: accept at edge t, streaming during the N cycles after edges
// t..t+N-1, out_valid high from edge t+N+1.
// -----------------------------------------------------------------------------
module stoch_add_seq
  import stoch_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] SEED_A = WIDTH'(8'h01),
  parameter logic [WIDTH-1:0] SEED_B = WIDTH'(8'hA5)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             dp_nrst,
  output logic             dp_a,
  output logic             dp_b,
  input  logic             dp_y
);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("stoch_add_seq: WIDTH must be in 4..16");
    end
    if (SEED_A == '0 || SEED_B == '0) begin : g_zero_seed
      $error("stoch_add_seq: LFSR seeds must be nonzero");
    end
    if (SEED_A == SEED_B) begin : g_same_seed
      $error("stoch_add_seq: SEED_A and SEED_B must differ");
    end
  endgenerate

  // Last value of the run counter: the run covers counts 0..N-1.
  localparam logic [WIDTH-1:0] RUN_LAST = WIDTH'((1 << WIDTH) - 2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] run_cnt_reg;
  logic [WIDTH-1:0] ones_reg;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;

  logic             accept;
  logic             running;

  assign accept  = (state_reg == IDLE) && in_valid && in_ready_reg;
  assign running = (state_reg == RUN);

  // ---------------------------------------------------------------------------
  // Stream generators: index 0 is stream A, index 1 is stream B.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sng_seed  [2];
  logic [WIDTH-1:0] sng_value [2];
  logic [1:0]       sng_bit;

  assign sng_seed[0]  = SEED_A;
  assign sng_seed[1]  = SEED_B;
  assign sng_value[0] = op_a_q;
  assign sng_value[1] = op_b_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sng
      stoch_sng #(
        .WIDTH (WIDTH)
      ) u_sng (
        .CLK     (CLK),
        .load    (accept),
        .en      (running),
        .seed    (sng_seed[gi]),
        .value   (sng_value[gi]),
        .bit_out (sng_bit[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  // DONE spends its first cycle with out_valid low: the ones counter takes
  // its final sample on the edge that enters DONE, and out_valid is
  // registered from the state, so the result is presented one edge later
  // and is stable from the moment it is valid.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      run_cnt_reg   <= '0;
      ones_reg      <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          if (accept) begin
            op_a_q       <= op_a;
            op_b_q       <= op_b;
            run_cnt_reg  <= '0;
            ones_reg     <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end

        RUN: begin
          if (dp_y) begin
            ones_reg <= ones_reg + WIDTH'(1);
          end
          run_cnt_reg <= run_cnt_reg + WIDTH'(1);
          if (run_cnt_reg == RUN_LAST) begin
            state_reg <= DONE;
          end
        end

        DONE: begin
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = ones_reg;
  assign busy      = (state_reg != IDLE);

  // The adder is held in reset outside RUN, so it clears on the edge that
  // enters RUN and every run starts from an empty adder counter.
  assign dp_nrst = nRST & running;
  assign dp_a    = running & sng_bit[0];
  assign dp_b    = running & sng_bit[1];

endmodule
